vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 The port clk SHALL be an input, 1 bit wide, and carry the 50 MHz system clock; it is the single clock.
REQ-010 The port rst SHALL be an input, 1 bit wide, and act as the reset: asynchronous, active-high.
REQ-011 The port vga_clk SHALL be an output, 1 bit wide, carrying the 25 MHz pixel clock to the DAC; it is the registered pixel enable.
REQ-012 The port hs SHALL be an output, 10 bits wide, carrying the horizontal pixel counter that feeds the image drawing stage.
REQ-013 The port vs SHALL be an output, 10 bits wide, carrying the vertical line counter that feeds the image drawing stage.
REQ-014 The port hsync SHALL be an output, 1 bit wide, carrying the active-low horizontal sync.
REQ-015 The port vsync SHALL be an output, 1 bit wide, carrying the active-low vertical sync.
REQ-016 The port blank_n SHALL be an output, 1 bit wide, that is high inside the visible area.
REQ-017 The port sync_n SHALL be an output, 1 bit wide, and be held constant at 0 because composite sync is unused.
REQ-018 The port frame_start SHALL be an output, 1 bit wide, carrying a one-clk pulse at the start of each frame.
REQ-019 The port line_start SHALL be an output, 1 bit wide, carrying a one-clk pulse at the start of each line.

Function
REQ-020 H_TOTAL and V_TOTAL are defined as follows and SHALL be used for all counter wrapping: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-021 The pixel enable register (vga_clk) SHALL toggle on every clk rising edge, giving a 25 MHz rate and a 50% duty cycle.
REQ-022 hs SHALL increment by 1 only on clk edges where vga_clk is 1 before the edge, so each hs value is held for 2 clk cycles.
REQ-023 When hs = H_TOTAL-1 at an advancing edge, hs SHALL wrap to 0, and vs SHALL increment by 1 on that same edge.
REQ-024 When vs = V_TOTAL-1 and hs = H_TOTAL-1 at an advancing edge, both hs and vs SHALL wrap to 0 on that same edge.
REQ-025 hs SHALL never exceed H_TOTAL-1, and vs SHALL never exceed V_TOTAL-1; counter arithmetic is unsigned and 10 bits wide.
REQ-026 hsync SHALL be 0 exactly when H_ACTIVE+H_FP <= hs < H_ACTIVE+H_FP+H_SYNC (default 656..751), and 1 otherwise.
REQ-027 vsync SHALL be 0 exactly when V_ACTIVE+V_FP <= vs < V_ACTIVE+V_FP+V_SYNC (default 490..491), and 1 otherwise.
REQ-028 blank_n SHALL be 1 exactly when hs < H_ACTIVE and vs < V_ACTIVE.
REQ-029 hsync, vsync and blank_n SHALL be decoded from the registered hs and vs, so they are aligned with hs/vs in the same clk cycle with zero added latency.
REQ-030 line_start SHALL be 1 for exactly one clk cycle: the first clk cycle in which hs = 0 after an hs wrap.
REQ-031 frame_start SHALL be 1 for exactly one clk cycle: the first clk cycle in which hs = 0 and vs = 0 after a frame wrap; line_start is also 1 in that cycle.
REQ-032 The frame period SHALL be H_TOTAL*V_TOTAL*2 clk cycles (default 840000), with no dropped or repeated counts.

Reset
REQ-033 While rst = 1, the outputs SHALL be held at these values: vga_clk = 0, hs = 0, vs = 0, hsync = 1, vsync = 1, blank_n = 1, sync_n = 0, frame_start = 0, line_start = 0.
REQ-034 rst SHALL act immediately, without waiting for a clk edge, including when asserted mid-line or mid-sync pulse; all counters restart from 0 and no partial sync pulse is completed.
REQ-035 After rst deasserts, the first clk edge SHALL set vga_clk to 1, and the second clk edge SHALL advance hs to 1.

Verification
REQ-036 Release rst, then run 4 clk cycles -> required response: vga_clk sequence 1,0,1,0; hs sequence 0,1,1,2; vs = 0; blank_n = 1.
REQ-037 Run to hs = 655, then hs = 656 -> required response: hsync 1 then 0; hsync returns to 1 at hs = 752; hsync low for exactly 192 clk.
REQ-038 Run to hs = 799, vs = 9 -> required response: at the next advancing edge hs = 0, vs = 10; line_start pulses for 1 clk; blank_n = 1.
REQ-039 Run to vs = 489 -> 490 -> required response: vsync low for exactly 2*800*2 = 3200 clk; blank_n = 0 throughout vs >= 480.
REQ-040 Run for a full frame -> required response: frame_start pulses are exactly 840000 clk apart; hs/vs never exceed 799/524.
REQ-041 Assert rst asynchronously mid-hsync (hs = 700, vs = 300) -> required response: in the same cycle hs = 0, vs = 0, hsync = 1, vga_clk = 0; after release the REQ-036 sequence repeats.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clk/2 pixel enable, h/v counters, sync and blank decode.
// Decodes are combinational from the registered counters (zero added latency); no backpressure.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       vga_clk,
  output logic [9:0] hs,
  output logic [9:0] vs,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic h_wrap;
  logic v_wrap;

  // Wraps only count on advancing edges, i.e. when the pixel enable is high.
  assign h_wrap = vga_clk && (hs == H_LAST);
  assign v_wrap = h_wrap && (vs == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_clk     <= 1'b0;
      hs          <= '0;
      vs          <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_clk     <= ~vga_clk;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (vga_clk) begin
        if (h_wrap) begin
          hs <= '0;
          vs <= v_wrap ? '0 : vs + 10'd1;
        end else begin
          hs <= hs + 10'd1;
        end
      end
    end
  end

  assign hsync   = ~((hs >= HS_START) && (hs < HS_END));
  assign vsync   = ~((vs >= VS_START) && (vs < VS_END));
  assign blank_n = (hs < H_VIS) && (vs < V_VIS);
  assign sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-size instance for line-level timing, small instance for frames.
module tb_vga_timing_gen;

  localparam int BHA = 20, BHF = 4, BHS = 6, BHB = 5;
  localparam int BVA = 12, BVF = 3, BVS = 2, BVB = 4;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BVT = BVA + BVF + BVS + BVB;
  localparam int BFRAME = BHT * BVT * 2;

  typedef struct packed {
    logic       vga_clk;
    logic [9:0] hs;
    logic [9:0] vs;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       sync_n;
    logic       frame_start;
    logic       line_start;
  } exp_t;

  localparam exp_t RST_EXP = '{vga_clk: 1'b0, hs: 10'd0, vs: 10'd0, hsync: 1'b1, vsync: 1'b1,
                               blank_n: 1'b1, sync_n: 1'b0, frame_start: 1'b0, line_start: 1'b0};

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic       vga_clk_a, hsync_a, vsync_a, blank_n_a, sync_n_a, frame_start_a, line_start_a;
  logic [9:0] hs_a, vs_a;
  logic       vga_clk_b, hsync_b, vsync_b, blank_n_b, sync_n_b, frame_start_b, line_start_b;
  logic [9:0] hs_b, vs_b;

  int vectors = 0;
  int miscompares = 0;
  int n_a, n_b;
  exp_t obs_a, obs_b;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .vga_clk(vga_clk_a), .hs(hs_a), .vs(vs_a),
    .hsync(hsync_a), .vsync(vsync_a), .blank_n(blank_n_a), .sync_n(sync_n_a),
    .frame_start(frame_start_a), .line_start(line_start_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
  ) u_b (
    .clk(clk), .rst(rst_b), .vga_clk(vga_clk_b), .hs(hs_b), .vs(vs_b),
    .hsync(hsync_b), .vsync(vsync_b), .blank_n(blank_n_b), .sync_n(sync_n_b),
    .frame_start(frame_start_b), .line_start(line_start_b)
  );

  assign obs_a = {vga_clk_a, hs_a, vs_a, hsync_a, vsync_a, blank_n_a, sync_n_a, frame_start_a, line_start_a};
  assign obs_b = {vga_clk_b, hs_b, vs_b, hsync_b, vsync_b, blank_n_b, sync_n_b, frame_start_b, line_start_b};

  // Reference time base: clk edges elapsed since reset release.
  always @(posedge clk or posedge rst_a) if (rst_a) n_a <= 0; else n_a <= n_a + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) n_b <= 0; else n_b <= n_b + 1;

  // Raster position follows directly from elapsed edges: one pixel per two clk.
  function automatic exp_t model(int n, int ha, int hf, int hsy, int hb,
                                 int va, int vf, int vsy, int vb);
    exp_t m;
    int ht, vt, pix, h, v;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    pix = n / 2;
    h = pix % ht;
    v = (pix / ht) % vt;
    m.vga_clk     = (n % 2) == 1;
    m.hs          = 10'(h);
    m.vs          = 10'(v);
    m.hsync       = !(h >= ha + hf && h < ha + hf + hsy);
    m.vsync       = !(v >= va + vf && v < va + vf + vsy);
    m.blank_n     = (h < ha) && (v < va);
    m.sync_n      = 1'b0;
    m.line_start  = (n > 0) && (n % 2 == 0) && (h == 0);
    m.frame_start = m.line_start && (v == 0);
    return m;
  endfunction

  function automatic exp_t model_a(int n);
    return model(n, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic exp_t model_b(int n);
    return model(n, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB);
  endfunction

  task automatic test_reset;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_a !== RST_EXP) begin
      miscompares++;
      $display("FAIL reset_a: got %h, expected %h", obs_a, RST_EXP);
    end
    vectors++;
    if (obs_b !== RST_EXP) begin
      miscompares++;
      $display("FAIL reset_b: got %h, expected %h", obs_b, RST_EXP);
    end
  endtask

  task automatic test_startup(input bit with_b);
    logic       ev[4];
    logic [9:0] eh[4];
    ev = '{1'b1, 1'b0, 1'b1, 1'b0};
    eh = '{10'd0, 10'd1, 10'd1, 10'd2};
    rst_a = 1'b0;
    if (with_b) rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({vga_clk_a, hs_a, vs_a, blank_n_a} !== {ev[i], eh[i], 10'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL startup[%0d]: got vga_clk=%b hs=%0d vs=%0d blank_n=%b, expected %b %0d 0 1",
                 i, vga_clk_a, hs_a, vs_a, blank_n_a, ev[i], eh[i]);
      end
      vectors++;
      if (obs_a !== model_a(n_a)) begin
        miscompares++;
        $display("FAIL startup_model_a: got %h, expected %h", obs_a, model_a(n_a));
      end
      if (with_b) begin
        vectors++;
        if (obs_b !== model_b(n_b)) begin
          miscompares++;
          $display("FAIL startup_model_b: got %h, expected %h", obs_b, model_b(n_b));
        end
      end
    end
  endtask

  task automatic test_hsync;
    int c = 0;
    int low = 1;
    while (hs_a != 10'd655 && c < 3000) begin
      @(negedge clk);
      c++;
      vectors++;
      if (obs_a !== model_a(n_a)) begin
        miscompares++;
        $display("FAIL hsync_model: got %h, expected %h", obs_a, model_a(n_a));
      end
    end
    vectors++;
    if ({hs_a, hsync_a} !== {10'd655, 1'b1}) begin
      miscompares++;
      $display("FAIL hsync_pre: got hs=%0d hsync=%b, expected 655 1", hs_a, hsync_a);
    end
    while (hs_a == 10'd655) @(negedge clk);
    vectors++;
    if ({hs_a, hsync_a} !== {10'd656, 1'b0}) begin
      miscompares++;
      $display("FAIL hsync_fall: got hs=%0d hsync=%b, expected 656 0", hs_a, hsync_a);
    end
    c = 0;
    while (c < 400) begin
      @(negedge clk);
      c++;
      if (hs_a == 10'd752) break;
      if (hsync_a == 1'b0) low++;
    end
    vectors++;
    if ({hs_a, hsync_a} !== {10'd752, 1'b1}) begin
      miscompares++;
      $display("FAIL hsync_rise: got hs=%0d hsync=%b, expected 752 1", hs_a, hsync_a);
    end
    vectors++;
    if (low != 192) begin
      miscompares++;
      $display("FAIL hsync_width: got %0d clk, expected 192", low);
    end
  endtask

  task automatic test_line_wrap;
    int c = 0;
    while (!(hs_a == 10'd799 && vs_a == 10'd9) && c < 20000) begin
      @(negedge clk);
      c++;
      vectors++;
      if (obs_a !== model_a(n_a)) begin
        miscompares++;
        $display("FAIL line_model: got %h, expected %h", obs_a, model_a(n_a));
      end
    end
    vectors++;
    if ({hs_a, vs_a} !== {10'd799, 10'd9}) begin
      miscompares++;
      $display("FAIL line_reach: got hs=%0d vs=%0d, expected 799 9", hs_a, vs_a);
    end
    c = 0;
    while (hs_a == 10'd799 && c < 4) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if ({hs_a, vs_a, line_start_a, blank_n_a} !== {10'd0, 10'd10, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL line_wrap: got hs=%0d vs=%0d ls=%b blank_n=%b, expected 0 10 1 1",
               hs_a, vs_a, line_start_a, blank_n_a);
    end
    @(negedge clk);
    vectors++;
    if ({hs_a, line_start_a} !== {10'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL line_pulse_len: got hs=%0d ls=%b, expected 0 0", hs_a, line_start_a);
    end
  endtask

  task automatic test_async_reset;
    int c = 0;
    while (hs_a != 10'd700 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if ({hs_a, hsync_a} !== {10'd700, 1'b0}) begin
      miscompares++;
      $display("FAIL arst_pre: got hs=%0d hsync=%b, expected 700 0", hs_a, hsync_a);
    end
    #2 rst_a = 1'b1;
    #1;
    vectors++;
    if ({hs_a, vs_a, hsync_a, vga_clk_a} !== {10'd0, 10'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL arst_immediate: got hs=%0d vs=%0d hsync=%b vga_clk=%b, expected 0 0 1 0",
               hs_a, vs_a, hsync_a, vga_clk_a);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_a !== RST_EXP) begin
      miscompares++;
      $display("FAIL arst_hold: got %h, expected %h", obs_a, RST_EXP);
    end
    test_startup(1'b0);
  endtask

  task automatic test_vsync;
    int c = 0;
    int low = 0;
    while (vs_b != 10'(BVA + BVF - 1) && c < 2 * BFRAME) begin
      @(negedge clk);
      c++;
      vectors++;
      if (obs_b !== model_b(n_b)) begin
        miscompares++;
        $display("FAIL vsync_model: got %h, expected %h", obs_b, model_b(n_b));
      end
    end
    c = 0;
    while (vs_b != 10'(BVA + BVF + BVS) && c < BFRAME) begin
      @(negedge clk);
      c++;
      if (vsync_b == 1'b0) low++;
      if (vs_b >= 10'(BVA)) begin
        vectors++;
        if (blank_n_b !== 1'b0) begin
          miscompares++;
          $display("FAIL vblank: got blank_n=%b at vs=%0d, expected 0", blank_n_b, vs_b);
        end
      end
    end
    vectors++;
    if (low != BVS * BHT * 2) begin
      miscompares++;
      $display("FAIL vsync_width: got %0d clk, expected %0d", low, BVS * BHT * 2);
    end
  endtask

  task automatic test_frame;
    int last = -1;
    int gaps = 0;
    for (int cyc = 0; cyc < 3 * BFRAME + 10; cyc++) begin
      @(negedge clk);
      vectors++;
      if (hs_b > 10'(BHT - 1) || vs_b > 10'(BVT - 1)) begin
        miscompares++;
        $display("FAIL frame_range: got hs=%0d vs=%0d, expected <= %0d %0d", hs_b, vs_b, BHT - 1, BVT - 1);
      end
      if (frame_start_b) begin
        vectors++;
        if ({hs_b, vs_b, line_start_b} !== {10'd0, 10'd0, 1'b1}) begin
          miscompares++;
          $display("FAIL frame_pulse: got hs=%0d vs=%0d ls=%b, expected 0 0 1", hs_b, vs_b, line_start_b);
        end
        if (last >= 0) begin
          gaps++;
          vectors++;
          if (cyc - last != BFRAME) begin
            miscompares++;
            $display("FAIL frame_period: got %0d clk, expected %0d", cyc - last, BFRAME);
          end
        end
        last = cyc;
      end
    end
    vectors++;
    if (gaps < 2) begin
      miscompares++;
      $display("FAIL frame_count: got %0d periods, expected at least 2", gaps);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 24; it++) begin
      int len, which, d;
      len = $urandom_range(50, 1500);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        vectors++;
        if (obs_a !== model_a(n_a)) begin
          miscompares++;
          $display("FAIL rand_model_a: got %h, expected %h", obs_a, model_a(n_a));
        end
        vectors++;
        if (obs_b !== model_b(n_b)) begin
          miscompares++;
          $display("FAIL rand_model_b: got %h, expected %h", obs_b, model_b(n_b));
        end
      end
      which = $urandom_range(0, 2);
      if (which != 0) begin
        d = $urandom_range(1, 3);
        #d;
        if (which == 1) rst_a = 1'b1; else rst_b = 1'b1;
        #1;
        vectors++;
        if ((which == 1 ? obs_a : obs_b) !== RST_EXP) begin
          miscompares++;
          $display("FAIL rand_arst: got %h, expected %h", which == 1 ? obs_a : obs_b, RST_EXP);
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_startup(1'b1);
    test_hsync();
    test_line_wrap();
    test_async_reset();
    test_vsync();
    test_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
